// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipelined RV32I control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  localparam logic [31:0] INSN_NOP  = 32'h0000_0013;
  localparam logic [31:0] INSN_MRET = 32'h3020_0073;

  // Full bundle produced by the decoder and held in the execute register.
  typedef struct packed {
    alu_op_t    alu_op;
    logic       rs1_sel;
    logic       rs2_sel;
    logic       reg_wr;
    logic       rd_en;
    logic       wr_en;
    logic       csr_rd;
    logic       csr_wr;
    logic       is_mret;
    logic [1:0] wb_sel;
  } ctrl_bundle_t;

  // Fields still needed once the instruction has left execute.
  typedef struct packed {
    logic       reg_wr;
    logic       rd_en;
    logic       wr_en;
    logic       csr_rd;
    logic       csr_wr;
    logic       is_mret;
    logic [1:0] wb_sel;
  } mem_bundle_t;

  // Fields still needed in write-back.
  typedef struct packed {
    logic       reg_wr;
    logic [1:0] wb_sel;
  } wb_bundle_t;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } start_state_t;

  localparam ctrl_bundle_t CTRL_ZERO = '{
    alu_op:  ALU_ADD,
    rs1_sel: 1'b0,
    rs2_sel: 1'b0,
    reg_wr:  1'b0,
    rd_en:   1'b0,
    wr_en:   1'b0,
    csr_rd:  1'b0,
    csr_wr:  1'b0,
    is_mret: 1'b0,
    wb_sel:  WB_MEM
  };

  localparam mem_bundle_t MEM_ZERO = '0;
  localparam wb_bundle_t  WB_ZERO  = '0;

  // funct3 -> ALU operation; alt selects SUB/SRA where the encoding allows it.
  function automatic alu_op_t alu_from_funct(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational decode of one RV32I instruction into a control bundle.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0]  instruction,
  output ctrl_bundle_t ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [4:0] rd;
  logic [4:0] rs1;

  assign opcode    = instruction[6:0];
  assign rd        = instruction[11:7];
  assign funct3    = instruction[14:12];
  assign rs1       = instruction[19:15];
  assign funct7_b5 = instruction[30];

  // Opcode-driven bundle; unknown opcodes and the canonical NOP stay at zero.
  always_comb begin
    ctrl = CTRL_ZERO;
    if (instruction != INSN_NOP) begin
      case (opcode)
        OP_R: begin
          ctrl.alu_op = alu_from_funct(funct3, funct7_b5);
          ctrl.reg_wr = 1'b1;
          ctrl.wb_sel = WB_ALU;
        end
        OP_IMM: begin
          // funct7[5] is part of the immediate except for SRAI
          ctrl.alu_op  = alu_from_funct(funct3, (funct3 == 3'd5) && funct7_b5);
          ctrl.rs2_sel = 1'b1;
          ctrl.reg_wr  = 1'b1;
          ctrl.wb_sel  = WB_ALU;
        end
        OP_LOAD: begin
          ctrl.rs2_sel = 1'b1;
          ctrl.reg_wr  = 1'b1;
          ctrl.rd_en   = 1'b1;
          ctrl.wb_sel  = WB_MEM;
        end
        OP_STORE: begin
          ctrl.rs2_sel = 1'b1;
          ctrl.wr_en   = 1'b1;
          ctrl.wb_sel  = WB_ALU;
        end
        OP_BRANCH: begin
          ctrl.rs1_sel = 1'b1;
          ctrl.rs2_sel = 1'b1;
          ctrl.wb_sel  = WB_ALU;
        end
        OP_JAL: begin
          ctrl.rs1_sel = 1'b1;
          ctrl.rs2_sel = 1'b1;
          ctrl.reg_wr  = 1'b1;
          ctrl.wb_sel  = WB_PC4;
        end
        OP_JALR: begin
          ctrl.rs2_sel = 1'b1;
          ctrl.reg_wr  = 1'b1;
          ctrl.wb_sel  = WB_PC4;
        end
        OP_LUI: begin
          ctrl.alu_op  = ALU_PASS_B;
          ctrl.rs2_sel = 1'b1;
          ctrl.reg_wr  = 1'b1;
          ctrl.wb_sel  = WB_ALU;
        end
        OP_AUIPC: begin
          ctrl.rs1_sel = 1'b1;
          ctrl.rs2_sel = 1'b1;
          ctrl.reg_wr  = 1'b1;
          ctrl.wb_sel  = WB_ALU;
        end
        OP_SYSTEM: begin
          ctrl.rs2_sel = 1'b1;
          ctrl.is_mret = (instruction == INSN_MRET);
          if (funct3 != 3'd0) begin
            ctrl.reg_wr = 1'b1;
            ctrl.csr_rd = 1'b1;
            // CSRRS/CSRRC(I) with a zero source only read the CSR
            ctrl.csr_wr = !(funct3[1] && (rs1 == 5'd0));
            ctrl.wb_sel = WB_CSR;
          end else begin
            ctrl.wb_sel = WB_ALU;
          end
        end
        default: ctrl = CTRL_ZERO;
      endcase
    end
    if (rd == 5'd0) ctrl.reg_wr = 1'b0;
  end

endmodule

// File: rtl/pipeline_controller.sv
// Pipelined control unit: decode, E/M/W control registers and fetch start-up.
module pipeline_controller
  import ctrl_pkg::*;
#(
  parameter int width     = 32,
  parameter int width_alu = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [width-1:0]     instruction_d,
  input  logic                 flush_e,
  output logic [width_alu-1:0] alu_op,
  output logic                 rs1_sel,
  output logic                 rs2_sel,
  output logic                 reg_wr_e,
  output logic                 rd_en,
  output logic                 wr_en,
  output logic                 csr_reg_rd,
  output logic                 csr_reg_wr,
  output logic                 is_mret,
  output logic                 reg_wr,
  output logic                 reg_wr_m,
  output logic [1:0]           wb_sel,
  output logic                 enable_pc,
  output logic                 enable_f
);

  ctrl_bundle_t dec;
  ctrl_bundle_t e_q;
  mem_bundle_t  m_q;
  wb_bundle_t   w_q;
  start_state_t state;
  start_state_t state_next;

  ctrl_decoder u_decoder (
    .instruction (instruction_d[31:0]),
    .ctrl        (dec)
  );

  // Execute register: takes the decoded bundle unless the hazard unit flushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) e_q <= CTRL_ZERO;
    else        e_q <= flush_e ? CTRL_ZERO : dec;
  end

  // Memory register: advances every cycle with the datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q <= MEM_ZERO;
    end else begin
      m_q <= '{
        reg_wr:  e_q.reg_wr,
        rd_en:   e_q.rd_en,
        wr_en:   e_q.wr_en,
        csr_rd:  e_q.csr_rd,
        csr_wr:  e_q.csr_wr,
        is_mret: e_q.is_mret,
        wb_sel:  e_q.wb_sel
      };
    end
  end

  // Write-back register: advances every cycle with the datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) w_q <= WB_ZERO;
    else        w_q <= '{reg_wr: m_q.reg_wr, wb_sel: m_q.wb_sel};
  end

  // Start-up state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RST;
    else        state <= state_next;
  end

  // Start-up next state: one idle START clock, then RUN until reset.
  always_comb begin
    state_next = state;
    case (state)
      ST_RST:   state_next = ST_START;
      ST_START: state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_RST;
    endcase
  end

  // Fetch enables are only released in RUN.
  always_comb begin
    enable_pc = 1'b0;
    enable_f  = 1'b0;
    if (state == ST_RUN) begin
      enable_pc = 1'b1;
      enable_f  = 1'b1;
    end
  end

  assign alu_op     = width_alu'(e_q.alu_op);
  assign rs1_sel    = e_q.rs1_sel;
  assign rs2_sel    = e_q.rs2_sel;
  assign reg_wr_e   = m_q.reg_wr;
  assign rd_en      = m_q.rd_en;
  assign wr_en      = m_q.wr_en;
  assign csr_reg_rd = m_q.csr_rd;
  assign csr_reg_wr = m_q.csr_wr;
  assign is_mret    = m_q.is_mret;
  assign reg_wr     = w_q.reg_wr;
  assign reg_wr_m   = w_q.reg_wr;
  assign wb_sel     = w_q.wb_sel;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios plus random
// instruction streams compared against a stage-history reference model.
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_d;
  logic        flush_e;
  logic [3:0]  alu_op;
  logic        rs1_sel, rs2_sel, reg_wr_e, rd_en, wr_en;
  logic        csr_reg_rd, csr_reg_wr, is_mret, reg_wr, reg_wr_m;
  logic [1:0]  wb_sel;
  logic        enable_pc, enable_f;

  pipeline_controller #(.width(32), .width_alu(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .instruction_d (instruction_d),
    .flush_e       (flush_e),
    .alu_op        (alu_op),
    .rs1_sel       (rs1_sel),
    .rs2_sel       (rs2_sel),
    .reg_wr_e      (reg_wr_e),
    .rd_en         (rd_en),
    .wr_en         (wr_en),
    .csr_reg_rd    (csr_reg_rd),
    .csr_reg_wr    (csr_reg_wr),
    .is_mret       (is_mret),
    .reg_wr        (reg_wr),
    .reg_wr_m      (reg_wr_m),
    .wb_sel        (wb_sel),
    .enable_pc     (enable_pc),
    .enable_f      (enable_f)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int alu;
    bit rs1, rs2, rw, rd_en, wr_en, csr_rd, csr_wr, mret;
    int wb;
  } mb_t;

  mb_t zb = '{default: 0};
  mb_t st_e, st_m, st_w;
  int  run_cnt = 0;

  // ALU code for each funct3 without the alternate bit; alternate adds one.
  int alu_base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                           7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};

  function automatic mb_t ref_decode(input logic [31:0] i);
    mb_t b = '{default: 0};
    logic [2:0] f3 = i[14:12];
    bit f7b = i[30];
    if (i == 32'h0000_0013) return b;
    case (i[6:0])
      7'h33: begin b.alu = alu_base[f3] + (((f3 == 0 || f3 == 5) && f7b) ? 1 : 0); b.rw = 1; b.wb = 1; end
      7'h13: begin b.alu = alu_base[f3] + ((f3 == 5 && f7b) ? 1 : 0); b.rs2 = 1; b.rw = 1; b.wb = 1; end
      7'h03: begin b.rs2 = 1; b.rw = 1; b.rd_en = 1; b.wb = 0; end
      7'h23: begin b.rs2 = 1; b.wr_en = 1; b.wb = 1; end
      7'h63: begin b.rs1 = 1; b.rs2 = 1; b.wb = 1; end
      7'h6F: begin b.rs1 = 1; b.rs2 = 1; b.rw = 1; b.wb = 2; end
      7'h67: begin b.rs2 = 1; b.rw = 1; b.wb = 2; end
      7'h37: begin b.alu = 10; b.rs2 = 1; b.rw = 1; b.wb = 1; end
      7'h17: begin b.rs1 = 1; b.rs2 = 1; b.rw = 1; b.wb = 1; end
      7'h73: begin
        b.rs2  = 1;
        b.mret = (i == 32'h3020_0073);
        if (f3 != 0) begin
          b.rw = 1; b.csr_rd = 1; b.wb = 3;
          b.csr_wr = !(f3[1] && i[19:15] == 5'd0);
        end else begin
          b.wb = 1;
        end
      end
      default: ;
    endcase
    if (i[11:7] == 5'd0) b.rw = 0;
    return b;
  endfunction

  function automatic logic [17:0] observed();
    return {alu_op, rs1_sel, rs2_sel, reg_wr_e, rd_en, wr_en, csr_reg_rd, csr_reg_wr,
            is_mret, reg_wr, reg_wr_m, wb_sel, enable_pc, enable_f};
  endfunction

  function automatic logic [17:0] expected();
    bit en = reset && (run_cnt >= 2);
    return {4'(st_e.alu), st_e.rs1, st_e.rs2, st_m.rw, st_m.rd_en, st_m.wr_en, st_m.csr_rd,
            st_m.csr_wr, st_m.mret, st_w.rw, st_w.rw, 2'(st_w.wb), en, en};
  endfunction

  task automatic cycle(input logic [31:0] ins, input logic fl);
    instruction_d = ins;
    flush_e = fl;
    @(posedge clk);
    if (!reset) begin
      st_e = zb; st_m = zb; st_w = zb; run_cnt = 0;
    end else begin
      st_w = st_m;
      st_m = st_e;
      st_e = fl ? zb : ref_decode(ins);
      if (run_cnt < 2) run_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    if (observed() !== 18'b0) begin miscompares++; $display("FAIL reset_async got %h want %h", observed(), 18'b0); end
    vectors++;
    for (int k = 0; k < 3; k++) begin
      cycle($urandom, 1'($urandom_range(0, 1)));
      if (observed() !== 18'b0) begin miscompares++; $display("FAIL reset_hold got %h want %h", observed(), 18'b0); end
      vectors++;
    end
    reset = 1'b1;
    cycle(32'h0, 1'b0);
    if (observed() !== 18'b0) begin miscompares++; $display("FAIL reset_start got %h want %h", observed(), 18'b0); end
    vectors++;
    cycle(32'h0, 1'b0);
    if (observed() !== 18'b11) begin miscompares++; $display("FAIL reset_run got %h want %h", observed(), 18'b11); end
    vectors++;
  endtask

  task automatic test_add();
    cycle(32'h0020_81B3, 1'b0);
    if ({alu_op, rs1_sel, rs2_sel} !== 6'b0000_00) begin miscompares++; $display("FAIL add_e got %b want %b", {alu_op, rs1_sel, rs2_sel}, 6'b0); end
    vectors++;
    cycle(32'h0000_0013, 1'b0);
    if (reg_wr_e !== 1'b1) begin miscompares++; $display("FAIL add_m got %b want 1", reg_wr_e); end
    vectors++;
    cycle(32'h0000_0013, 1'b0);
    if ({reg_wr, reg_wr_m, wb_sel} !== 4'b1101) begin miscompares++; $display("FAIL add_w got %b want 1101", {reg_wr, reg_wr_m, wb_sel}); end
    vectors++;
  endtask

  task automatic test_load_store();
    cycle(32'h0000_A103, 1'b0);
    cycle(32'h0020_A223, 1'b0);
    if (rd_en !== 1'b1) begin miscompares++; $display("FAIL lw_m got %b want 1", rd_en); end
    vectors++;
    cycle(32'h0000_0013, 1'b0);
    if ({wb_sel, reg_wr} !== 3'b001) begin miscompares++; $display("FAIL lw_w got %b want 001", {wb_sel, reg_wr}); end
    vectors++;
    if ({wr_en, reg_wr_e, rd_en} !== 3'b100) begin miscompares++; $display("FAIL sw_m got %b want 100", {wr_en, reg_wr_e, rd_en}); end
    vectors++;
  endtask

  task automatic test_sra_x0();
    cycle(32'h4020_D1B3, 1'b0);
    if (alu_op !== 4'd7) begin miscompares++; $display("FAIL sra_e got %0d want 7", alu_op); end
    vectors++;
    cycle(32'h0000_0033, 1'b0);
    if (alu_op !== 4'd0) begin miscompares++; $display("FAIL addx0_e got %0d want 0", alu_op); end
    vectors++;
    cycle(32'h0000_0013, 1'b0);
    if (reg_wr_e !== 1'b0) begin miscompares++; $display("FAIL addx0_m got %b want 0", reg_wr_e); end
    vectors++;
    cycle(32'h0000_0013, 1'b0);
    if ({reg_wr, reg_wr_m} !== 2'b00) begin miscompares++; $display("FAIL addx0_w got %b want 00", {reg_wr, reg_wr_m}); end
    vectors++;
  endtask

  task automatic test_csr_mret();
    cycle(32'h3052_9073, 1'b0);
    cycle(32'h3020_0073, 1'b0);
    if ({csr_reg_wr, csr_reg_rd, is_mret} !== 3'b110) begin miscompares++; $display("FAIL csr_m got %b want 110", {csr_reg_wr, csr_reg_rd, is_mret}); end
    vectors++;
    cycle(32'h0000_0013, 1'b0);
    if ({wb_sel, reg_wr} !== 3'b110) begin miscompares++; $display("FAIL csr_w got %b want 110", {wb_sel, reg_wr}); end
    vectors++;
    if ({is_mret, csr_reg_rd, csr_reg_wr} !== 3'b100) begin miscompares++; $display("FAIL mret_m got %b want 100", {is_mret, csr_reg_rd, csr_reg_wr}); end
    vectors++;
    cycle(32'h0000_0013, 1'b0);
    if (is_mret !== 1'b0) begin miscompares++; $display("FAIL mret_once got %b want 0", is_mret); end
    vectors++;
  endtask

  task automatic test_flush();
    cycle(32'h00C0_00EF, 1'b1);
    if ({alu_op, rs1_sel, rs2_sel} !== 6'b0) begin miscompares++; $display("FAIL flush_e got %b want 0", {alu_op, rs1_sel, rs2_sel}); end
    vectors++;
    cycle(32'h00C0_00EF, 1'b0);
    if ({rs1_sel, reg_wr_e} !== 2'b10) begin miscompares++; $display("FAIL jal_e got %b want 10", {rs1_sel, reg_wr_e}); end
    vectors++;
    cycle(32'h0000_0013, 1'b0);
    if ({reg_wr, wb_sel, reg_wr_e} !== 4'b0001) begin miscompares++; $display("FAIL flush_w got %b want 0001", {reg_wr, wb_sel, reg_wr_e}); end
    vectors++;
    cycle(32'h0000_0013, 1'b0);
    if ({wb_sel, reg_wr} !== 3'b101) begin miscompares++; $display("FAIL jal_w got %b want 101", {wb_sel, reg_wr}); end
    vectors++;
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] ins = $urandom;
      int pick = $urandom_range(0, 11);
      logic fl = ($urandom_range(0, 7) == 0);
      if (pick < 10) ins[6:0] = ops[pick];
      else if (pick == 10) ins = $urandom_range(0, 1) ? 32'h3020_0073 : 32'h0000_0013;
      if ($urandom_range(0, 3) == 0) ins[19:15] = 5'd0;
      if ($urandom_range(0, 5) == 0) ins[11:7] = 5'd0;
      cycle(ins, fl);
      if (observed() !== expected()) begin miscompares++; $display("FAIL rand_vec ins=%h flush=%b got %h want %h", ins, fl, observed(), expected()); end
      vectors++;
    end
  endtask

  task automatic test_reset_mid();
    test_random(20);
    #2;
    reset = 1'b0;
    st_e = zb; st_m = zb; st_w = zb; run_cnt = 0;
    #1;
    if (observed() !== 18'b0) begin miscompares++; $display("FAIL midreset_async got %h want %h", observed(), 18'b0); end
    vectors++;
    for (int k = 0; k < 2; k++) begin
      cycle($urandom, 1'b0);
      if (observed() !== expected()) begin miscompares++; $display("FAIL midreset_hold got %h want %h", observed(), expected()); end
      vectors++;
    end
    reset = 1'b1;
    test_random(30);
  endtask

  initial begin
    st_e = zb; st_m = zb; st_w = zb;
    reset = 1'b1;
    instruction_d = 32'h0;
    flush_e = 1'b0;
    #2 reset = 1'b0;
    test_reset();
    test_add();
    test_load_store();
    test_sra_x0();
    test_csr_mret();
    test_flush();
    test_random(400);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Pipelined control unit for the five-stage RV32I core. It decodes the instruction held in the fetch/decode pipeline register and carries the resulting control bundle through execute, memory and write-back stage registers. Each control output is therefore aligned with the instruction the datapath is processing in that stage. It also sequences fetch start-up after reset and tracks the datapath's execute-stage flush.

## Interface
- width, 32, instruction/data width
- width_alu, 4, ALU opcode width
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instruction_d  in  width  decode-stage instruction (datapath fetch_instruction)
- flush_e  in  1  hazard-unit flush of the decode→execute register
- alu_op  out  width_alu  execute-stage ALU operation
- rs1_sel  out  1  execute: 0 = rs1 data, 1 = PC
- rs2_sel  out  1  execute: 0 = rs2 data, 1 = immediate
- reg_wr_e  out  1  reg-write flag of the memory-stage instruction (hazard unit)
- rd_en, wr_en  out  1  memory-stage load / store
- csr_reg_rd, csr_reg_wr, is_mret  out  1  memory-stage CSR read / write / MRET
- reg_wr, reg_wr_m  out  1  write-back-stage register write (same value)
- wb_sel  out  2  write-back: 0 mem, 1 ALU, 2 PC+4, 3 CSR
- enable_pc, enable_f  out  1  fetch enables

## Operation
- The combinational decoder maps instruction_d[6:0] to a bundle: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
- alu_op comes from funct3/funct7[5].
  - R-type uses funct7[5] to select SUB/SRA.
  - I-ALU uses funct7[5] only for SRAI.
  - LOAD, STORE, BRANCH, JAL, JALR and AUIPC use ADD.
  - LUI uses PASS_B.
- rs1_sel = 1 for BRANCH, JAL, AUIPC.
- rs2_sel = 1 for every opcode except R-type.
- Register write is set for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC, and SYSTEM with funct3 != 0.
  - Register write is forced to 0 when rd = x0.
- wb_sel is set per opcode:
  - LOAD → 0
  - JAL/JALR → 2
  - SYSTEM CSR ops → 3
  - all other opcodes → 1
- SYSTEM with funct3 != 0 sets csr_reg_rd = 1.
  - It also sets csr_reg_wr = 1, except when funct3[1] = 1 and rs1/uimm = 0. In that case csr_reg_wr = 0, so CSRRS/CSRRC with x0 do not write.
- is_mret = 1 only for exactly 0x30200073.
- Unknown opcode and 0x00000013 (NOP) → all-zero bundle with alu_op = ADD.

## Timing
- Stage registers: decode→E, E→M, M→W, all clocked on the rising edge of clk.
- E register loads the decoded bundle every cycle; flush_e = 1 loads the all-zero bundle instead.
- E→M and M→W registers advance unconditionally, matching the datapath.
- Output alignment:
  - alu_op, rs1_sel, rs2_sel come from the E register.
  - reg_wr_e, rd_en, wr_en, csr_* and is_mret come from the M register.
  - reg_wr, reg_wr_m and wb_sel come from the W register.
- Latency from instruction_d to its outputs: execute 1 cycle, memory 2 cycles, write-back 3 cycles.
- Reset (reset = 0, asynchronous): all stage registers are cleared to the zero bundle, so every output is 0 and alu_op = ADD (0).
  - enable_pc and enable_f are held at 0.
- Start-up FSM: RST → START → RUN.
  - START lasts exactly one clock after reset deassertion; enable_* stay 0 during it.
  - In RUN, enable_pc = enable_f = 1 until the next reset.
- A reset asserted mid-operation clears everything in the same instant; instructions in flight are discarded.
- flush_e and a new instruction_d in the same cycle: flush_e wins.
- A datapath stall (stall_d) needs no controller action, because instruction_d is held by the datapath.

## Structure
- Shared package `ctrl_pkg`:
  - alu_op enum: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10
  - opcode localparams
  - wb_sel constants
  - packed struct `ctrl_bundle_t`
- Sub-module `ctrl_decoder` (purely combinational instruction → ctrl_bundle_t).
- The top level holds the three stage registers and the start-up FSM.

## Test plan
- Reset held 3 cycles then released → all outputs 0 during reset and for the first clock after release; enable_pc = enable_f = 1 from the second clock.
- instruction_d = 0x002081B3 (add x3,x1,x2) → next cycle alu_op = ADD, rs1_sel = 0, rs2_sel = 0; cycle +2 reg_wr_e = 1; cycle +3 reg_wr = reg_wr_m = 1, wb_sel = 1.
- 0x0000A103 (lw x2,0(x1)) → cycle +2 rd_en = 1; cycle +3 wb_sel = 0, reg_wr = 1. Then 0x0020A223 (sw) → cycle +2 wr_en = 1, reg_wr_e = 0.
- 0x4020D1B3 (sra) → alu_op = SRA; 0x00000033 (add x0) → reg_wr stays 0 at every stage.
- 0x30529073 (csrrw x0,mtvec,x5) → cycle +2 csr_reg_wr = 1, csr_reg_rd = 1; cycle +3 wb_sel = 3, reg_wr = 0. Then 0x30200073 → cycle +2 is_mret = 1 for exactly one cycle.
- Decode 0x00C000EF (jal) with flush_e = 1 in the same cycle → E/M/W carry the zero bundle; the following unflushed jal gives rs1_sel = 1 and, 3 cycles later, wb_sel = 2.
